// File: rtl/mac_requant.sv
// ============================================================================
// Module      : mac_requant
// Description : Requantizes signed Q(int_in_p).(frac_in_p) MAC results to
//               Q(int_out_p).(frac_out_p) with saturation, then queues them
//               in a 2-entry elastic buffer on a valid/ready stream.
//               Optional macro MAC_REQUANT_ROUND_EN selects round-half-up;
//               without it the dropped fraction bits are truncated (floor).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_requant #(
  parameter int int_in_p   = 16,
  parameter int frac_in_p  = 16,
  parameter int int_out_p  = 8,
  parameter int frac_out_p = 8
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [int_in_p+frac_in_p-1:0]       data_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  output logic [int_out_p+frac_out_p-1:0]     data_o,
  output logic                                sat_o,
  output logic                                valid_o,
  input  logic                                ready_i
);

  localparam int W_IN  = int_in_p + frac_in_p;
  localparam int W_OUT = int_out_p + frac_out_p;
  localparam int SHIFT = frac_in_p - frac_out_p;

  // Output range limits expressed in the widened (W_IN+1) arithmetic domain.
  localparam logic        [W_IN:0] ONE_W   = {{W_IN{1'b0}}, 1'b1};
  localparam logic signed [W_IN:0] SAT_MAX = $signed((ONE_W << (W_OUT - 1)) - ONE_W);
  localparam logic signed [W_IN:0] SAT_MIN = ~SAT_MAX;

  if (!((frac_in_p >= frac_out_p) && (frac_out_p >= 0) &&
        (int_in_p >= int_out_p) && (int_out_p >= 1))) begin : g_param_check
    $error("mac_requant: illegal format parameters");
  end

  // --------------------------------------------------------------------------
  // Requantization datapath
  // --------------------------------------------------------------------------
  logic signed [W_IN:0]    w_ext;
  logic signed [W_IN:0]    w_biased;
  logic signed [W_IN:0]    w_q;
  logic [W_OUT-1:0]        w_res_data;
  logic                    w_res_sat;

  // One extra bit of headroom so the rounding increment can never wrap.
  assign w_ext = $signed({data_i[W_IN-1], data_i});

`ifdef MAC_REQUANT_ROUND_EN
  if (SHIFT > 0) begin : g_round
    localparam logic [W_IN:0] ROUND_INC = ONE_W << (SHIFT - 1);
    assign w_biased = w_ext + $signed(ROUND_INC);
  end else begin : g_no_round
    assign w_biased = w_ext;
  end
`else
  assign w_biased = w_ext;
`endif

  assign w_q = w_biased >>> SHIFT;

  // Clamp to the output range; exactly-min is representable and not flagged.
  always_comb begin
    w_res_data = w_q[W_OUT-1:0];
    w_res_sat  = 1'b0;
    if (w_q > SAT_MAX) begin
      w_res_data = SAT_MAX[W_OUT-1:0];
      w_res_sat  = 1'b1;
    end else if (w_q < SAT_MIN) begin
      w_res_data = SAT_MIN[W_OUT-1:0];
      w_res_sat  = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry elastic buffer: head drives the outputs directly, tail holds the
  // second sample while the consumer stalls.
  // --------------------------------------------------------------------------
  logic [1:0]        count_q, count_d;
  logic              ready_q, ready_d;
  logic [W_OUT-1:0]  head_data_q, head_data_d;
  logic              head_sat_q, head_sat_d;
  logic [W_OUT-1:0]  tail_data_q, tail_data_d;
  logic              tail_sat_q, tail_sat_d;
  logic              w_push;
  logic              w_pop;

  assign w_push = valid_i & ready_q;
  assign w_pop  = (count_q != 2'd0) & ready_i;

  // Next-state for occupancy, entries and the registered ready.
  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_sat_d  = head_sat_q;
    tail_data_d = tail_data_q;
    tail_sat_d  = tail_sat_q;
    case ({w_push, w_pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = w_res_data;
          head_sat_d  = w_res_sat;
          count_d     = 2'd1;
        end else begin
          tail_data_d = w_res_data;
          tail_sat_d  = w_res_sat;
          count_d     = 2'd2;
        end
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_sat_d  = tail_sat_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_sat_d  = tail_sat_q;
          tail_data_d = w_res_data;
          tail_sat_d  = w_res_sat;
        end else begin
          head_data_d = w_res_data;
          head_sat_d  = w_res_sat;
        end
      end
      default: begin
      end
    endcase
    ready_d = (count_d != 2'd2);
  end

  // State registers with synchronous reset that discards buffered samples.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q     <= 2'd0;
      ready_q     <= 1'b1;
      head_data_q <= '0;
      head_sat_q  <= 1'b0;
      tail_data_q <= '0;
      tail_sat_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      ready_q     <= ready_d;
      head_data_q <= head_data_d;
      head_sat_q  <= head_sat_d;
      tail_data_q <= tail_data_d;
      tail_sat_q  <= tail_sat_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_data_q;
  assign sat_o   = head_sat_q;

endmodule

`default_nettype wire

// File: doc/mac_requant.md
Name: mac_requant

Overview:
- Consumer at the output end of the mac valid/ready stream.
- Accepts signed Q(int_in_p).(frac_in_p) accumulator results.
- Requantizes each to signed Q(int_out_p).(frac_out_p) by dropping fraction LSBs and saturating at the output range.
- Buffers results in a 2-entry elastic buffer so the MAC can run at full throughput under downstream backpressure.

Parameters:
- int_in_p, 16, integer bits of input (incl. sign)
- frac_in_p, 16, fraction bits of input
- int_out_p, 8, integer bits of output (incl. sign)
- frac_out_p, 8, fraction bits of output
- Legal range: frac_in_p >= frac_out_p >= 0; int_in_p >= int_out_p >= 1. Violation -> elaboration-time $error.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- data_i  input  int_in_p+frac_in_p  signed input sample
- valid_i  input  1  input valid
- ready_o  output  1  input ready (buffer not full)
- data_o  output  int_out_p+frac_out_p  signed requantized sample
- sat_o  output  1  data_o was clamped; qualified by valid_o
- valid_o  output  1  output valid
- ready_i  input  1  downstream ready

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high (reset_i, sampled on posedge clk_i). Polarity and synchronicity are fixed.
- Reset values: buffer empty, valid_o=0, ready_o=1, data_o=0, sat_o=0.
- Handshakes:
  - Input transfer when valid_i & ready_o at posedge.
  - Output transfer when valid_o & ready_i at posedge.
  - valid_o does not depend combinationally on ready_i.
  - ready_o is registered and depends only on occupancy. No combinational path from ready_i or valid_i to ready_o.
- Latency: a sample accepted at edge N is visible on data_o/sat_o with valid_o=1 after edge N, if the buffer was empty. Samples leave strictly in order.
- Buffer: 2 entries, each holding {data_o, sat_o}. Occupancy counter takes 0..2; ready_o = (count != 2).
  - Simultaneous push and pop: count unchanged; data advances. This is legal at count 1 and count 2.
  - At count 2, a push is impossible because ready_o=0.
  - At count 0, no pop occurs because valid_o=0.
- Throughput: 1 sample/cycle sustained while ready_i=1.
- Output stability: while valid_o=1 & ready_i=0, data_o and sat_o hold stable.
- Arithmetic (combinational, before the buffer write):
  - shift = frac_in_p - frac_out_p.
  - Truncate mode: q = data_i >>> shift (arithmetic shift, floor toward -inf).
  - Rounding mode (see Optional Feature): q = (data_i + 2^(shift-1)) >>> shift, computed in width int_in_p+frac_in_p+1 so the add cannot wrap. When shift=0, no add.
  - Saturation: max = 2^(Wout-1)-1, min = -2^(Wout-1), where Wout = int_out_p+frac_out_p.
    - q > max -> data=max, sat=1.
    - q < min -> data=min, sat=1.
    - Otherwise data = low Wout bits of q, sat=0.
  - Exact min (e.g. -128.0 in Q8.8) is not saturation.
- Reset mid-operation: buffered contents are discarded. The cycle after reset asserts, valid_o=0 and ready_o=1. Inputs presented during reset are not accepted.
- X handling: valid_o and ready_o never X after the first reset edge.

Optional Feature:
- Macro: MAC_REQUANT_ROUND_EN.
- Defined: round-half-up (toward +inf on ties) as above.
- Undefined: pure truncation (floor).
- Saturation, latency and handshake behaviour are identical in both builds.

Test Plan:
- Basic conversion, ready_i=1: data_i 0x0001_8000 (1.5) -> data_o 0x0180, sat_o=0, valid_o one cycle after accept. Then 0xFF80_0000 (-128.0) -> 0x8000, sat_o=0.
- Saturation:
  - 0x0080_0000 (128.0) -> 0x7FFF, sat_o=1.
  - 0xFF7F_0000 (-129.0) -> 0x8000, sat_o=1.
  - 0x7FFF_FFFF -> 0x7FFF, sat_o=1 in both builds.
- Rounding:
  - 0x0000_0080 -> 0x0000 with truncate, 0x0001 with MAC_REQUANT_ROUND_EN.
  - 0xFFFF_FF80 -> 0xFFFF with truncate, 0x0000 with MAC_REQUANT_ROUND_EN.
- Backpressure: ready_i=0, offer 3 samples (1.0, 2.0, 3.0).
  - First two accepted; ready_o=0 the cycle after the 2nd accept; 3rd held.
  - Raise ready_i: outputs 0x0100, 0x0200, 0x0300 in order, no loss or duplication.
- Full-throughput stream: valid_i=1, ready_i=1 for 50 back-to-back ramp samples -> one output per cycle, ready_o stays 1, outputs match the scoreboard.
- Reset mid-operation: fill 2 entries with ready_i=0, assert reset_i 2 cycles -> valid_o=0, ready_o=1 next cycle. A new sample after release emerges alone with the correct value.
